// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with one outstanding bus request and a single-entry output register
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ireq_valid/ireq_addr               request to the instruction bus (address = pc)
//   iresp_addr_ok/iresp_data_ok/iresp_data   bus accept, response strobe, instruction word
//   redirect_valid/redirect_pc         flush and new target from later stages (highest priority)
//   out_valid/out_ready/out_instr/out_pc/out_exc   handshake to decode
// Build option: define FETCH_MISALIGN_CHECK_EN to turn a misaligned pc into an exception entry
// (nop instruction, out_exc=1) instead of a bus fetch.
module fetch_unit #(
   parameter logic [63:0] PC_RESET = 64'h8000_0000,
   parameter logic [63:0] PC_STEP  = 64'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        out_exc
);
   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;
   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d, pend_pc_q, pend_pc_d, out_pc_q, out_pc_d;
   logic        pend_v_q, pend_v_d, out_exc_q, out_exc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        mis, req, cap;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign mis = |pc_q[1:0];
`else
   assign mis = 1'b0;
`endif
   assign req = state_q == FETCH && !mis;
   // entering HOLD from anywhere else means a fresh entry is captured
   assign cap = state_d == HOLD && state_q != HOLD;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= PC_RESET;
         pend_v_q    <= 1'b0;
         pend_pc_q   <= '0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_exc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_v_q    <= pend_v_d;
         pend_pc_q   <= pend_pc_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_exc_q   <= out_exc_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH:
            if (mis) state_d = redirect_valid ? FETCH : HOLD;
            else if (iresp_addr_ok)
               // a redirect now or one parked earlier makes this response stale
               state_d = (redirect_valid || pend_v_q) ? (iresp_data_ok ? FETCH : DISCARD)
                                                      : (iresp_data_ok ? HOLD : WAIT);
         WAIT:
            if (redirect_valid) state_d = iresp_data_ok ? FETCH : DISCARD;
            else if (iresp_data_ok) state_d = HOLD;
         HOLD:
            if (redirect_valid || out_ready) state_d = FETCH;
         DISCARD:
            if (iresp_data_ok) state_d = FETCH;
      endcase
   end
   always_comb begin
      pc_d      = pc_q;
      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;
      if (redirect_valid) begin
         // an unaccepted request must keep its address, so park the target
         if (req && !iresp_addr_ok) begin
            pend_v_d  = 1'b1;
            pend_pc_d = redirect_pc;
         end else begin
            pc_d     = redirect_pc;
            pend_v_d = 1'b0;
         end
      end else if (req && iresp_addr_ok && pend_v_q) begin
         pc_d     = pend_pc_q;
         pend_v_d = 1'b0;
      end else if (state_q == HOLD && out_ready) pc_d = pc_q + PC_STEP;
      out_instr_d = cap ? (mis ? 32'h0000_0013 : iresp_data) : out_instr_q;
      out_pc_d    = cap ? pc_q : out_pc_q;
      out_exc_d   = cap ? mis : out_exc_q;
   end
   always_comb begin
      ireq_valid = !reset && req;
      ireq_addr  = pc_q;
      out_valid  = !reset && state_q == HOLD;
      out_instr  = reset ? 32'h0 : out_instr_q;
      out_pc     = reset ? 64'h0 : out_pc_q;
      out_exc    = !reset && out_exc_q;
   end
endmodule
